instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage directly upstream of instruction_memory. Holds the byte-addressed PC and drives
//  the word index into the combinational-read instruction ROM. Registers the returned word into
//  the IF/ID pipeline register with a valid bit. Supports decode-side stall, execute-side redirect
//  (branch/jump/flush) and fault detection for misaligned or out-of-range fetch targets.
// PARAMETERS
//  RESET_PC    32'h0000_0000                    byte address of first fetch after reset
//  ADDR_W      INSTRUCTION_MEMORY_ADDRESS_WIDTH  word-index width driven to the ROM
//  IMEM_DEPTH  INSTRUCTION_MEMORY_DEPTH          ROM depth in words; valid PC range 0..IMEM_DEPTH*4-4
//  NOP_INSN    32'h0000_0013                    value of if_instruction when not valid (addi x0,x0,0)
// PORTS
//  clk                  in   1                  single clock, all state updates on rising edge
//  rst                  in   1                  synchronous, active-high reset
//  stall                in   1                  decode cannot accept; hold PC and IF/ID
//  redirect_valid       in   1                  load redirect_pc into PC, flush IF/ID
//  redirect_pc          in   32                 redirect target, byte address
//  instruction_address  out  ADDR_W             word index to ROM = pc[ADDR_W+1:2]
//  instruction_data     in   INSTRUCTION_WIDTH  ROM read data, combinational from instruction_address
//  if_valid             out  1                  IF/ID holds a real instruction
//  if_instruction       out  INSTRUCTION_WIDTH  fetched instruction (NOP_INSN when !if_valid)
//  if_pc                out  32                 byte PC of if_instruction
//  if_pc_plus4          out  32                 if_pc + 4
//  fetch_fault          out  1                  level, high while in FAULT state
//  fault_cause          out  2                  2'b01 misaligned, 2'b10 out-of-range, 2'b00 none
//  fault_pc             out  32                 offending PC, latched on FAULT entry
// BEHAVIOUR
//  Reset (rst=1 at edge, dominates everything):
//    pc=RESET_PC, state=IDLE, if_valid=0, if_instruction=NOP_INSN, if_pc=0, if_pc_plus4=0.
//    Also fetch_fault=0, fault_cause=0, fault_pc=0.
//  FSM: IDLE, RUN, FAULT.
//    IDLE: one bubble cycle, no capture, if_valid=0; next state RUN (or per redirect rules).
//    RUN: PC legality is checked before each capture.
//      Illegal PC = pc[1:0]!=0 or pc[31:2]>=IMEM_DEPTH.
//      Illegal and no redirect: go to FAULT, if_valid<=0, fault_pc<=pc, fault_cause set.
//        Misaligned has priority over out-of-range when both apply.
//      Legal, !stall, !redirect: IF/ID<={instruction_data,pc,pc+4,valid=1}; pc<=pc+4.
//      stall, !redirect: pc and all IF/ID outputs hold exactly.
//    FAULT: pc holds, if_valid=0; exits only via redirect (or rst).
//  Redirect (any state, priority over stall):
//    pc<=redirect_pc, if_valid<=0, if_instruction<=NOP_INSN, fetch at redirect_pc begins next cycle.
//    Next state is RUN; the target is legality-checked in RUN before its first capture.
//    Leaving FAULT via redirect clears fault_cause to 0; fault_pc keeps its last value.
//  Latency: instruction at PC P appears on if_* at the edge that ends the cycle in which
//    instruction_address = P>>2 (1 cycle, ROM is combinational).
//  Redirect-to-first-valid latency: 2 edges (flush edge, then capture edge).
//  instruction_address is always pc[ADDR_W+1:2], including in IDLE/FAULT; ROM reads are side-effect free.
//  Arithmetic: pc+4 is 32-bit modulo. The range check faults before any wrap reaches a capture.
//  if_pc_plus4 is computed from the captured pc, not the current pc.
//  redirect_valid with stall: redirect wins, IF/ID flushed (stalled instruction is discarded).
// TESTING
//  Seq: rst 2 cyc, ROM[i]=i+1 -> IDLE 1 cyc, then if_valid=1.
//    if_pc=0,4,8,... with if_instruction=1,2,3,... on consecutive edges.
//  Stall: stall=1 for 3 cyc while if_pc=0x8 -> if_pc/if_instruction frozen at 0x8/3, pc held.
//    On release next if_pc=0xC.
//  Redirect: redirect_valid=1, redirect_pc=0x40 at if_pc=0x10 -> next edge if_valid=0.
//    Following edge if_pc=0x40, if_instruction=ROM[16].
//  Redirect+stall same cycle to 0x20 -> flush wins; if_valid=0, then if_pc=0x20 with stall=0.
//  Misaligned: redirect_pc=0x22 -> FAULT, fetch_fault=1, fault_cause=01, fault_pc=0x22, if_valid=0.
//    Redirect to 0x0 -> fault_cause=00, if_pc=0x0 two edges later.
//  Range (IMEM_DEPTH=16): run sequentially -> last valid if_pc=0x3C.
//    Then FAULT with fault_cause=10, fault_pc=0x40.
//  Reset mid-run: rst=1 at if_pc=0x24 -> next edge if_valid=0, pc=RESET_PC, state IDLE, fault cleared.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage feeding a combinational-read instruction ROM. Holds the byte PC,
//   drives the ROM word index, and registers the returned word into the IF/ID
//   register along with a valid bit. Supports a decode-side stall, an
//   execute-side redirect (branch/jump/flush), and fault detection for
//   misaligned or out-of-range fetch targets.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   stall                decode cannot accept: PC and IF/ID hold
//   redirect_valid/_pc   load a new PC and flush IF/ID (wins over stall)
//   instruction_address  ROM word index, always pc[ADDR_W+1:2]
//   instruction_data     ROM read data (combinational from instruction_address)
//   if_valid/_instruction/_pc/_pc_plus4   IF/ID pipeline register
//   fetch_fault          high while in the FAULT state
//   fault_cause          01 misaligned, 10 out-of-range, 00 none
//   fault_pc             offending PC, latched on FAULT entry
module instruction_fetch #(
    parameter logic [31:0]                  RESET_PC          = 32'h0000_0000,
    parameter int unsigned                  ADDR_W            = 8,
    parameter int unsigned                  IMEM_DEPTH        = 256,
    parameter int unsigned                  INSTRUCTION_WIDTH = 32,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSN          = 'h13
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic [ADDR_W-1:0]            instruction_address,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_data,
    output logic                         if_valid,
    output logic [INSTRUCTION_WIDTH-1:0] if_instruction,
    output logic [31:0]                  if_pc,
    output logic [31:0]                  if_pc_plus4,
    output logic                         fetch_fault,
    output logic [1:0]                   fault_cause,
    output logic [31:0]                  fault_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        misaligned;
    logic        out_of_range;

    assign instruction_address = pc[ADDR_W+1:2];

    // Word index compared at full width so that PCs beyond the ROM never alias.
    always_comb begin
        misaligned   = (pc[1:0] != 2'b00);
        out_of_range = ({2'b00, pc[31:2]} >= 32'(IMEM_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSN;
            if_pc          <= '0;
            if_pc_plus4    <= '0;
            fetch_fault    <= 1'b0;
            fault_cause    <= '0;
            fault_pc       <= '0;
        end else if (redirect_valid) begin
            // Redirect from any state; target is legality-checked in RUN
            // before its first capture. fault_pc deliberately keeps its value.
            state          <= RUN;
            pc             <= redirect_pc;
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSN;
            fetch_fault    <= 1'b0;
            fault_cause    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= RUN;
                    if_valid <= 1'b0;
                end
                RUN: begin
                    // Legality dominates stall: an illegal PC faults even
                    // while decode is holding.
                    if (misaligned || out_of_range) begin
                        state          <= FAULT;
                        if_valid       <= 1'b0;
                        if_instruction <= NOP_INSN;
                        fetch_fault    <= 1'b1;
                        fault_pc       <= pc;
                        fault_cause    <= misaligned ? 2'b01 : 2'b10;
                    end else if (!stall) begin
                        if_valid       <= 1'b1;
                        if_instruction <= instruction_data;
                        if_pc          <= pc;
                        if_pc_plus4    <= pc + 32'd4;
                        pc             <= pc + 32'd4;
                    end
                end
                FAULT: begin
                    if_valid <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
